// File: rtl/lut_load_ctrl.sv
// Load/rotate controller for a serially loaded, rotatable lookup table.
// Writes stream an entry MSB first into the LUT; rotates shift the whole table by whole entries.
module lut_load_ctrl #(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    input  logic [OUT_WIDTH-1:0] wr_data,
    output logic                wr_ready,
    input  logic                rot_req,
    input  logic [IN_WIDTH-1:0] rot_count,
    output logic                rot_done,
    output logic                lut_d,
    output logic                lut_cs_n,
    output logic                lut_rot_n,
    output logic [IN_WIDTH:0]   entry_cnt,
    output logic                table_full,
    output logic                busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] ROTATE = 2'd2;

    // One counter serves both the bit index of a shift and the step index of a rotate.
    localparam int CNT_W = ($clog2(OUT_WIDTH + 1) > IN_WIDTH) ? $clog2(OUT_WIDTH + 1) : IN_WIDTH;
    localparam int ECW   = IN_WIDTH + 1;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(OUT_WIDTH);
    localparam logic [ECW-1:0]   FULL_CNT   = {1'b1, {IN_WIDTH{1'b0}}};

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [CNT_W-1:0]     step_cnt;
    logic [OUT_WIDTH-1:0] shift_reg;
    logic [IN_WIDTH-1:0]  rot_k;

    logic wr_accept;
    logic rot_accept;
    logic shift_last;
    logic rot_last;
    logic shift_active;
    logic rot_active;

    assign wr_accept    = (state == IDLE) && wr_valid;
    assign rot_accept   = (state == IDLE) && rot_req && !wr_valid;
    assign shift_last   = (state == SHIFT) && (step_cnt == SHIFT_LAST);
    assign rot_last     = (state == ROTATE) && (step_cnt == CNT_W'(rot_k));
    assign shift_active = (state == SHIFT) && !shift_last;
    assign rot_active   = (state == ROTATE) && !rot_last;

    assign wr_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign table_full = (entry_cnt == FULL_CNT);

    // A write wins over a simultaneous rotate; the rotate is simply seen again back in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_valid) begin
                    state_next = SHIFT;
                end else if (rot_req && (rot_count != '0)) begin
                    state_next = ROTATE;
                end
            end
            SHIFT: begin
                if (shift_last) begin
                    state_next = IDLE;
                end
            end
            ROTATE: begin
                if (rot_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (wr_accept || rot_accept) begin
            step_cnt <= '0;
        end else if (shift_active || rot_active) begin
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (wr_accept) begin
            shift_reg <= wr_data;
        end else if (shift_active) begin
            shift_reg <= shift_reg << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_k <= '0;
        end else if (rot_accept) begin
            rot_k <= rot_count;
        end
    end

    // LUT strobes are registered so they are glitch-free and mutually exclusive by state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_cs_n  <= 1'b1;
            lut_rot_n <= 1'b1;
            lut_d     <= 1'b0;
            rot_done  <= 1'b0;
        end else begin
            lut_cs_n  <= !shift_active;
            lut_rot_n <= !rot_active;
            lut_d     <= shift_active ? shift_reg[OUT_WIDTH-1] : 1'b0;
            rot_done  <= (rot_accept && (rot_count == '0)) || rot_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_cnt <= '0;
        end else if (shift_last && (entry_cnt != FULL_CNT)) begin
            entry_cnt <= entry_cnt + ECW'(1);
        end
    end

endmodule

// File: tb/tb_lut_load_ctrl.sv
// Scoreboard bench for lut_load_ctrl with a behavioural model of the attached LUT.
module tb_lut_load_ctrl;

    localparam int IW = 2;
    localparam int OW = 8;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [OW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rot_req = 1'b0;
    logic [IW-1:0] rot_count = '0;
    logic          rot_done;
    logic          lut_d;
    logic          lut_cs_n;
    logic          lut_rot_n;
    logic [IW:0]   entry_cnt;
    logic          table_full;
    logic          busy;

    always #5 clk = ~clk;

    lut_load_ctrl #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rot_req(rot_req), .rot_count(rot_count), .rot_done(rot_done),
        .lut_d(lut_d), .lut_cs_n(lut_cs_n), .lut_rot_n(lut_rot_n),
        .entry_cnt(entry_cnt), .table_full(table_full), .busy(busy)
    );

    // Attached LUT: shift chain fed at the LSB, rotate moves entry i to i-1 and entry 0 to the top.
    logic [NE*OW-1:0] lut_chain;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lut_chain <= '0;
        else if (!lut_cs_n) lut_chain <= {lut_chain[NE*OW-2:0], lut_d};
        else if (!lut_rot_n) lut_chain <= {lut_chain[OW-1:0], lut_chain[NE*OW-1:OW]};
    end

    function automatic logic [OW-1:0] lut_entry(input int sel);
        return lut_chain[sel*OW +: OW];
    endfunction

    typedef struct {
        logic          is_rot;
        logic [IW:0]   cnt;
        logic          full;
        logic [OW-1:0] e0;
        logic [OW-1:0] e3;
        int            pulse;
        int            ready_low;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic is_rot, input logic [IW:0] cnt, input logic full,
                           input logic [OW-1:0] e0, input logic [OW-1:0] e3,
                           input int pulse, input int ready_low);
        exp_t e;
        e.is_rot = is_rot; e.cnt = cnt; e.full = full; e.e0 = e0; e.e3 = e3;
        e.pulse = pulse; e.ready_low = ready_low;
        sb.push_back(e);
    endtask

    // Monitor: count strobe/ready low cycles and compare at each completed operation.
    logic prev_cs_n = 1'b1;
    int   cs_low = 0, rot_low = 0, rdy_low = 0;
    bit   overlap = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cs_low = 0; rot_low = 0; rdy_low = 0; prev_cs_n = 1'b1;
        end else begin
            if (!lut_cs_n && !lut_rot_n) overlap = 1'b1;
            if (!lut_cs_n) cs_low++;
            if (!lut_rot_n) rot_low++;
            if (!wr_ready) rdy_low++;
            if ((!prev_cs_n && lut_cs_n) || rot_done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_event", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("evt_kind", 32'(rot_done), 32'(mon_e.is_rot));
                    checkOutput("entry_cnt", 32'(entry_cnt), 32'(mon_e.cnt));
                    checkOutput("table_full", 32'(table_full), 32'(mon_e.full));
                    checkOutput("lut_sel0", 32'(lut_entry(0)), 32'(mon_e.e0));
                    checkOutput("lut_sel3", 32'(lut_entry(3)), 32'(mon_e.e3));
                    checkOutput("pulse_len", 32'(mon_e.is_rot ? rot_low : cs_low), 32'(mon_e.pulse));
                    checkOutput("ready_low", 32'(rdy_low), 32'(mon_e.ready_low));
                end
                cs_low = 0; rot_low = 0; rdy_low = 0;
            end
            prev_cs_n = lut_cs_n;
        end
    end

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic wr, input logic [OW-1:0] data,
                                 input logic rot, input logic [IW-1:0] cnt);
        bit ok;
        waitReady(ok);
        if (ok) begin
            wr_valid = wr; wr_data = data; rot_req = rot; rot_count = cnt;
            @(posedge clk); #1;
            wr_valid = 1'b0;
            wr_data = OW'($urandom);
            if (wr && rot) begin
                waitReady(ok);
                if (ok) begin
                    @(posedge clk); #1;
                end
            end
            rot_req = 1'b0;
            rot_count = IW'($urandom);
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_cs_n"}, 32'(lut_cs_n), 32'd1);
        checkOutput({tag, "_rot_n"}, 32'(lut_rot_n), 32'd1);
        checkOutput({tag, "_lut_d"}, 32'(lut_d), 32'd0);
        checkOutput({tag, "_rot_done"}, 32'(rot_done), 32'd0);
        checkOutput({tag, "_entry_cnt"}, 32'(entry_cnt), 32'd0);
        checkOutput({tag, "_table_full"}, 32'(table_full), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkResetState("por");
        rst_n = 1'b1;
        #1 checkOutput("ready_after_rst", 32'(wr_ready), 32'd1);

        // Fill the table: first byte ends at the top entry, last at entry 0.
        pushExp(0, 3'd1, 0, 8'hA1, 8'h00, 8, 9); applyStimulus(1, 8'hA1, 0, 0);
        pushExp(0, 3'd2, 0, 8'hB2, 8'h00, 8, 9); applyStimulus(1, 8'hB2, 0, 0);
        pushExp(0, 3'd3, 0, 8'hC3, 8'h00, 8, 9); applyStimulus(1, 8'hC3, 0, 0);
        pushExp(0, 3'd4, 1, 8'hD4, 8'hA1, 8, 9); applyStimulus(1, 8'hD4, 0, 0);

        pushExp(1, 3'd4, 1, 8'hC3, 8'hD4, 1, 2); applyStimulus(0, 8'h00, 1, 2'd1);
        pushExp(1, 3'd4, 1, 8'hD4, 8'hA1, 3, 4); applyStimulus(0, 8'h00, 1, 2'd3);

        // Write into a full table displaces the oldest entry.
        pushExp(0, 3'd4, 1, 8'hE5, 8'hB2, 8, 9); applyStimulus(1, 8'hE5, 0, 0);

        pushExp(1, 3'd4, 1, 8'hE5, 8'hB2, 0, 0); applyStimulus(0, 8'h00, 1, 2'd0);
        checkOutput("rot0_busy_a", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("rot0_busy_b", 32'(busy), 32'd0);

        // Simultaneous write and rotate: write first, then rotate by 2.
        pushExp(0, 3'd4, 1, 8'h96, 8'hC3, 8, 9);
        pushExp(1, 3'd4, 1, 8'hD4, 8'hE5, 2, 3);
        applyStimulus(1, 8'h96, 1, 2'd2);
        waitDrain();

        // Reset in the middle of a shift aborts it.
        applyStimulus(1, 8'h5A, 0, 0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetState("mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("ready_after_rst2", 32'(wr_ready), 32'd1);

        pushExp(0, 3'd1, 0, 8'h3C, 8'h00, 8, 9); applyStimulus(1, 8'h3C, 0, 0);
        waitDrain();

        checkOutput("cs_rot_overlap", 32'(overlap), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
